// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execution stage combining ALU-control decode with the datapath.
// Single-cycle ops finish at the accept edge. Multiply is an iterative shift-add
// over WIDTH cycles. Results sit in a one-entry output register with backpressure.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    typedef enum logic [3:0] {
        FN_ADD  = 4'd0,
        FN_SUB  = 4'd1,
        FN_MULT = 4'd2,
        FN_SLL  = 4'd3,
        FN_SRL  = 4'd4,
        FN_AND  = 4'd5,
        FN_OR   = 4'd6,
        FN_SLT  = 4'd7,
        FN_XOR  = 4'd8,
        FN_INV  = 4'd9
    } fn_t;

    state_t           state;
    fn_t              fn;
    logic             dec_err;
    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;

    // Request is taken only when idle and the output register is free or draining.
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Decode {alu_op, op_code} into an internal function; reserved codes fall back to add with err.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        fn      = FN_ADD;
        dec_err = 1'b0;
        case (alu_op)
            2'b10: fn = FN_ADD;
            2'b01: fn = FN_SUB;
            2'b00: begin
                if (op_code <= 4'd9) begin
                    fn = fn_t'(op_code);
                end else begin
                    dec_err = 1'b1;
                end
            end
            default: dec_err = 1'b1;
        endcase
    end

    // Single-cycle datapath; multiply is handled by the iterative path instead.
    always_comb begin
        alu_res = '0;
        case (fn)
            FN_ADD:  alu_res = a + b;
            FN_SUB:  alu_res = a - b;
            FN_SLL:  alu_res = a << b[SHAMT_W-1:0];
            FN_SRL:  alu_res = a >> b[SHAMT_W-1:0];
            FN_AND:  alu_res = a & b;
            FN_OR:   alu_res = a | b;
            FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            FN_XOR:  alu_res = a ^ b;
            FN_INV:  alu_res = ~a;
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    // Control FSM, multiply iteration and the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            result    <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so a later completion in
            // this block cleanly overrides the drain clear on the same edge.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (fn == FN_MULT) begin
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= MUL;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            err       <= dec_err;
                            out_valid <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        result    <= acc_next;
                        zero      <= (acc_next == '0);
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a WIDTH=32 instance for single-cycle ops and
// backpressure, a WIDTH=8 instance for the iterative multiply and mid-multiply reset.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic        w_zero, w_err, w_busy;
    logic [1:0]  w_alu_op;
    logic [3:0]  w_op_code;
    logic [31:0] w_a, w_b, w_result;

    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic        n_zero, n_err, n_busy;
    logic [1:0]  n_alu_op;
    logic [3:0]  n_op_code;
    logic [7:0]  n_a, n_b, n_result;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .alu_op(w_alu_op), .op_code(w_op_code), .a(w_a), .b(w_b),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .result(w_result), .zero(w_zero), .err(w_err), .busy(w_busy)
    );

    alu_exec_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n_in_valid), .in_ready(n_in_ready),
        .alu_op(n_alu_op), .op_code(n_op_code), .a(n_a), .b(n_b),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .result(n_result), .zero(n_zero), .err(n_err), .busy(n_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_w(input logic [1:0] op, input logic [3:0] fc,
                           input logic [31:0] av, input logic [31:0] bv);
        w_in_valid = 1'b1;
        w_alu_op   = op;
        w_op_code  = fc;
        w_a        = av;
        w_b        = bv;
    endtask

    task automatic drive_n(input logic [1:0] op, input logic [3:0] fc,
                           input logic [7:0] av, input logic [7:0] bv);
        n_in_valid = 1'b1;
        n_alu_op   = op;
        n_op_code  = fc;
        n_a        = av;
        n_b        = bv;
    endtask

    // Issue one single-cycle op on the 32-bit unit and check the result one edge later.
    task automatic op_w(input string tag, input logic [1:0] op, input logic [3:0] fc,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_res, input logic exp_zero, input logic exp_err);
        drive_w(op, fc, av, bv);
        check({tag, "_in_ready"}, {31'd0, w_in_ready}, 32'd1);
        step();
        check({tag, "_out_valid"}, {31'd0, w_out_valid}, 32'd1);
        check({tag, "_result"}, w_result, exp_res);
        check({tag, "_zero"}, {31'd0, w_zero}, {31'd0, exp_zero});
        check({tag, "_err"}, {31'd0, w_err}, {31'd0, exp_err});
    endtask

    // 8-bit multiply: result must appear exactly 8 edges after the accept edge.
    task automatic run_mult(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic [7:0] exp_res, input logic exp_zero);
        int cyc;
        drive_n(2'b00, 4'd2, av, bv);
        step();
        // A competing add is presented during the multiply and must be ignored.
        drive_n(2'b10, 4'd0, 8'd1, 8'd1);
        check({tag, "_busy_start"}, {31'd0, n_busy}, 32'd1);
        check({tag, "_valid_start"}, {31'd0, n_out_valid}, 32'd0);
        cyc = 0;
        while (!n_out_valid && cyc < 20) begin
            check({tag, "_in_ready_mul"}, {31'd0, n_in_ready}, 32'd0);
            step();
            cyc++;
        end
        n_in_valid = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'd8);
        check({tag, "_result"}, {24'd0, n_result}, {24'd0, exp_res});
        check({tag, "_zero"}, {31'd0, n_zero}, {31'd0, exp_zero});
        check({tag, "_err"}, {31'd0, n_err}, 32'd0);
        check({tag, "_busy_end"}, {31'd0, n_busy}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        w_in_valid  = 1'b0;
        w_out_ready = 1'b1;
        w_alu_op    = 2'b00;
        w_op_code   = 4'd0;
        w_a         = '0;
        w_b         = '0;
        n_in_valid  = 1'b0;
        n_out_ready = 1'b1;
        n_alu_op    = 2'b00;
        n_op_code   = 4'd0;
        n_a         = '0;
        n_b         = '0;

        step();
        step();
        check("rst_result", w_result, 32'd0);
        check("rst_out_valid", {31'd0, w_out_valid}, 32'd0);
        check("rst_zero", {31'd0, w_zero}, 32'd0);
        check("rst_err", {31'd0, w_err}, 32'd0);
        check("rst_busy", {31'd0, w_busy}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, w_in_ready}, 32'd1);

        // Back-to-back single-cycle ops, one per clock.
        op_w("add_5_7",    2'b10, 4'd0, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0);
        op_w("add_1_2",    2'b10, 4'd0, 32'd1,        32'd2,        32'd3,        1'b0, 1'b0);
        op_w("add_100",    2'b10, 4'd0, 32'd100,      32'd200,      32'd300,      1'b0, 1'b0);
        op_w("add_wrap",   2'b00, 4'd0, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 1'b0);
        op_w("sub_eq",     2'b01, 4'd0, 32'h1234,     32'h1234,     32'd0,        1'b1, 1'b0);
        op_w("sub_wrap",   2'b00, 4'd1, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0);
        op_w("slt_m1_1",   2'b00, 4'd7, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0);
        op_w("slt_min_0",  2'b00, 4'd7, 32'h80000000, 32'd0,        32'd1,        1'b0, 1'b0);
        op_w("slt_5_m3",   2'b00, 4'd7, 32'd5,        32'hFFFFFFFD, 32'd0,        1'b1, 1'b0);
        op_w("sll_1_4",    2'b00, 4'd3, 32'd1,        32'd4,        32'h10,       1'b0, 1'b0);
        op_w("sll_amt0",   2'b00, 4'd3, 32'hABCD,     32'h20,       32'hABCD,     1'b0, 1'b0);
        op_w("srl_31",     2'b00, 4'd4, 32'h80000000, 32'd31,       32'd1,        1'b0, 1'b0);
        op_w("and",        2'b00, 4'd5, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1'b0);
        op_w("or",         2'b00, 4'd6, 32'hF0F0,     32'hFF00,     32'hFFF0,     1'b0, 1'b0);
        op_w("xor",        2'b00, 4'd8, 32'hF0F0,     32'hFF00,     32'h0FF0,     1'b0, 1'b0);
        op_w("invert",     2'b00, 4'd9, 32'hF0F0,     32'hFF00,     32'hFFFF0F0F, 1'b0, 1'b0);
        op_w("illegal_12", 2'b00, 4'd12, 32'd3,       32'd4,        32'd7,        1'b0, 1'b1);
        op_w("reserved",   2'b11, 4'd0, 32'd1,        32'd1,        32'd2,        1'b0, 1'b1);
        op_w("err_clear",  2'b10, 4'd0, 32'd0,        32'd0,        32'd0,        1'b1, 1'b0);
        w_in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, w_out_valid}, 32'd0);

        // Backpressure: the held result blocks a new request until the consumer drains it.
        w_out_ready = 1'b0;
        drive_w(2'b10, 4'd0, 32'd1, 32'd1);
        step();
        check("bp_valid", {31'd0, w_out_valid}, 32'd1);
        check("bp_result", w_result, 32'd2);
        drive_w(2'b10, 4'd0, 32'd10, 32'd10);
        #1;
        check("bp_in_ready_low", {31'd0, w_in_ready}, 32'd0);
        step();
        step();
        check("bp_hold_result", w_result, 32'd2);
        check("bp_hold_valid", {31'd0, w_out_valid}, 32'd1);
        w_out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", {31'd0, w_in_ready}, 32'd1);
        step();
        check("bp_new_result", w_result, 32'd20);
        check("bp_new_valid", {31'd0, w_out_valid}, 32'd1);
        w_in_valid = 1'b0;
        step();
        check("bp_drained", {31'd0, w_out_valid}, 32'd0);

        // Iterative multiply on the 8-bit unit.
        run_mult("mul_13_11", 8'd13,  8'd11, 8'h8F, 1'b0);
        run_mult("mul_by_0",  8'h55,  8'd0,  8'h00, 1'b1);
        run_mult("mul_ff_ff", 8'hFF,  8'hFF, 8'h01, 1'b0);

        // Reset in the middle of a multiply discards the partial product.
        drive_n(2'b00, 4'd2, 8'd9, 8'd9);
        step();
        n_in_valid = 1'b0;
        check("mr_busy", {31'd0, n_busy}, 32'd1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("mr_result", {24'd0, n_result}, 32'd0);
        check("mr_out_valid", {31'd0, n_out_valid}, 32'd0);
        check("mr_busy_clr", {31'd0, n_busy}, 32'd0);
        check("mr_zero", {31'd0, n_zero}, 32'd0);
        check("mr_err", {31'd0, n_err}, 32'd0);
        check("mr_w_result", w_result, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("mr_in_ready", {31'd0, n_in_ready}, 32'd1);
        drive_n(2'b10, 4'd0, 8'd2, 8'd2);
        step();
        n_in_valid = 1'b0;
        check("mr_add_valid", {31'd0, n_out_valid}, 32'd1);
        check("mr_add_result", {24'd0, n_result}, 32'd4);
        for (int i = 0; i < 10; i++) begin
            step();
            check("mr_no_stale", {31'd0, n_out_valid}, 32'd0);
        end
        check("mr_result_kept", {24'd0, n_result}, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised execution stage that merges ALU-control decode with the datapath.
- Takes {alu_op, op_code} plus two WIDTH-bit operands over a valid/ready handshake and decodes the function internally.
- Single-cycle ops complete in 1 cycle. Multiply runs as an iterative shift-add over WIDTH cycles.
- Result, zero flag and decode-error flag are held in a one-entry output register with backpressure. Sits between register read and writeback/branch resolution.

Parameters:
- WIDTH, 32, operand and result width; must be at least 4.
- SHAMT_W, $clog2(WIDTH), number of low bits of b used as shift amount.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request this cycle.
- alu_op  in  2  10 = load/store (add), 01 = branch (sub), 00 = R-type (use op_code), 11 = reserved.
- op_code  in  4  R-type function select.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B / shift amount.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- zero  out  1  registered (result == 0).
- err  out  1  registered: request was reserved/illegal.
- busy  out  1  multiply in progress.

Behaviour:
- Decode, with internal 4-bit function code:
  - alu_op=10 -> 0000 add.
  - alu_op=01 -> 0001 sub.
  - alu_op=00: op_code 0..9 -> function = op_code. Mapping: 0 add, 1 sub, 2 mult, 3 sll, 4 srl, 5 and, 6 or, 7 slt, 8 xor, 9 invert.
  - alu_op=00 with op_code 10..15, or alu_op=11 -> add, err=1 for that result.
- Arithmetic rules:
  - add/sub wrap modulo 2^WIDTH.
  - mult returns the low WIDTH bits of the unsigned product.
  - sll/srl are logical shifts of a by b[SHAMT_W-1:0].
  - slt is signed: result = {WIDTH-1 zeros, a<b}.
  - invert: result = ~a; b is ignored.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - The result register updates only when a result completes. It holds while out_valid && !out_ready.
  - out_valid clears on out_valid && out_ready unless a new result completes on the same edge. In that case out_valid stays 1 with the new data.
- State machine IDLE, MUL:
  - IDLE, accept of a non-mult op: result/zero/err are written at the accept edge, out_valid=1 next cycle. Latency is 1, so back-to-back throughput is 1 per cycle with out_ready=1.
  - IDLE, accept of mult: latch a as multiplicand, b as multiplier, accumulator=0, cnt=0. Go to MUL and set busy=1.
  - MUL, each edge: if multiplier[0], accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, cnt++.
  - MUL, on the edge with cnt==WIDTH-1: write the final accumulator to result, set out_valid=1, return to IDLE, clear busy. out_valid is first seen WIDTH cycles after the accept edge.
  - in_ready=0 throughout MUL. in_valid, a and b are ignored during MUL.
  - An output register still occupied at MUL completion is impossible: accept required it to be free or draining, and no other result completes while in MUL.
- Reset (asynchronous, any cycle, including mid-multiply):
  - state=IDLE, cnt=0, accumulator=0.
  - result=0, zero=0, err=0, out_valid=0, busy=0.
  - in_ready=1 in the first cycle after rst_n rises.
  - A partially computed product is discarded with no output.
- Boundary cases:
  - Shift amount 0 returns a.
  - mult by 0 still takes WIDTH cycles.
  - sub of equal operands gives zero=1 (branch compare).
  - slt with a=most-negative, b=0 -> 1.

Test Plan:
- WIDTH=32, alu_op=10, a=5, b=7, out_ready=1 -> next cycle out_valid=1, result=12, zero=0, err=0. Back-to-back requests on consecutive cycles each return after 1 cycle.
- alu_op=01, a=b=0x1234 -> result=0, zero=1. Then alu_op=00, op_code=7, a=0xFFFFFFFF, b=1 -> result=1.
- WIDTH=8, alu_op=00, op_code=2, a=13, b=11 -> busy=1, in_ready=0 for 8 cycles; out_valid rises 8 cycles after accept with result=0x8F. Then 0xFF*0xFF -> result=0x01.
- out_ready=0 after an add (a=1, b=1) -> result=2 holds, in_ready=0, a new request is not taken. Raise out_ready -> drains, next request accepted that edge.
- alu_op=00, op_code=12, a=3, b=4 -> result=7, err=1. Then alu_op=11, a=1, b=1 -> result=2, err=1.
- Start mult (a=9, b=9); assert rst_n=0 on cycle 3 -> all outputs 0 immediately, busy=0. After release, an add a=2, b=2 returns result=4 with no stale product.
